disp_arb: RTL

DISP_ARB -- requirements
Module: disp_arb

---
 rtl/disp_arb.sv | 116 +++++++++++
 1 files changed

// File: rtl/disp_arb.sv
// Round-robin arbiter sharing one 4-digit hex display among NREQ requesters with a minimum hold time.
// Optional macro DISP_ARB_PRIO0_EN: requester 0 may preempt the current owner before hold expiry.
module disp_arb #(
    parameter int NREQ = 4,
    parameter int HOLD = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   data_in,
    output logic [NREQ-1:0]      grant,
    output logic [15:0]          data_out,
    output logic                 switch
);

    localparam int          IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CW      = $clog2(HOLD);
    localparam int unsigned NREQ_U  = NREQ;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD - 1);

    typedef enum logic {S_IDLE, S_OWN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     data_q, data_d;
    logic            switch_q, switch_d;

    logic            rr_found;
    logic [IW-1:0]   rr_pick;
    logic [IW-1:0]   rr_idx;
    int unsigned     idx;

    // Search starts just after the last owner; the last owner itself is visited last.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = owner_q;
        rr_idx   = '0;
        idx      = 0;
        for (int unsigned i = 1; i <= NREQ_U; i++) begin
            idx    = (32'(owner_q) + i) % NREQ_U;
            rr_idx = IW'(idx);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        switch_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    state_d  = S_OWN;
                    owner_d  = rr_pick;
`ifdef DISP_ARB_PRIO0_EN
                    if (req[0]) owner_d = '0;
`endif
                    cnt_d    = '0;
                    switch_d = 1'b1;
                end
            end
            S_OWN: begin
                if (req[owner_q]) data_d = data_in[32'(owner_q)*16 +: 16];
`ifdef DISP_ARB_PRIO0_EN
                // Preemption waits one cycle after a handover so switch never pulses twice in a row.
                if (req[0] && owner_q != '0 && !switch_q) begin
                    owner_d  = '0;
                    cnt_d    = '0;
                    switch_d = 1'b1;
                end else
`endif
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!rr_found) begin
                    state_d = S_IDLE;
                end else if (rr_pick != owner_q) begin
                    owner_d  = rr_pick;
                    cnt_d    = '0;
                    switch_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= IW'(NREQ - 1);
            cnt_q    <= '0;
            data_q   <= '0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            switch_q <= switch_d;
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == S_OWN) grant[owner_q] = 1'b1;
    end

    assign data_out = data_q;
    assign switch   = switch_q;

endmodule
